// File: rtl/program_loader_rom.sv
// Writable 16x8 instruction ROM with a nibble-stream loader that holds the CPU in reset while loading.
// Define PROGRAM_LOADER_CHECKSUM_EN to add the trailing checksum check and the ERROR state.
module program_loader_rom #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data,
  input  logic                load_req,
  input  logic                wr_valid,
  input  logic [DATA_W/2-1:0] wr_nibble,
  output logic                wr_ready,
  output logic                n_cpu_reset,
  output logic                loading,
  output logic                load_err
);

  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam int unsigned HALF_W = DATA_W/2;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {RUN, LOAD_HI, LOAD_LO, RELEASE, CHK_HI, CHK_LO, ERROR} state_t;
`else
  typedef enum logic [1:0] {RUN, LOAD_HI, LOAD_LO, RELEASE} state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [HALF_W-1:0]   hi_q, hi_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                we;
  logic [DATA_W-1:0]   wdata;
  logic                xfer;
  logic                ready_d;
  logic                wr_ready_q, n_cpu_reset_q, loading_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    wdata   = {hi_q, wr_nibble};
    xfer    = wr_valid & wr_ready_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    // A load request wins over any transfer presented in the same cycle.
    if (load_req) begin
      state_d = LOAD_HI;
      ptr_d   = '0;
      hi_d    = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD_HI: if (xfer) begin
          hi_d    = wr_nibble;
          state_d = LOAD_LO;
        end
        LOAD_LO: if (xfer) begin
          we    = 1'b1;
          ptr_d = ptr_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d = sum_q + wdata;
`endif
          if (&ptr_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = CHK_HI;
`else
            state_d = RELEASE;
            cnt_d   = 4'(RELEASE_CYCLES);
`endif
          end else begin
            state_d = LOAD_HI;
          end
        end
        RELEASE: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK_HI: if (xfer) begin
          hi_d    = wr_nibble;
          state_d = CHK_LO;
        end
        CHK_LO: if (xfer) begin
          if (wdata == sum_q) begin
            err_d   = 1'b0;
            state_d = RELEASE;
            cnt_d   = 4'(RELEASE_CYCLES);
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
`endif
        default: ;
      endcase
    end
    ready_d = (state_d == LOAD_HI) || (state_d == LOAD_LO)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              || (state_d == CHK_HI) || (state_d == CHK_LO)
`endif
              ;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= RUN;
      ptr_q         <= '0;
      hi_q          <= '0;
      cnt_q         <= '0;
      wr_ready_q    <= 1'b0;
      n_cpu_reset_q <= 1'b0;
      loading_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hi_q          <= hi_d;
      cnt_q         <= cnt_d;
      wr_ready_q    <= ready_d;
      n_cpu_reset_q <= (state_d == RUN);
      loading_q     <= (state_d != RUN);
      if (we) mem_q[ptr_q] <= wdata;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q         <= sum_d;
      err_q         <= err_d;
`endif
    end
  end

  assign data        = (state_q == RUN) ? mem_q[addr] : '0;
  assign wr_ready    = wr_ready_q;
  assign n_cpu_reset = n_cpu_reset_q;
  assign loading     = loading_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign load_err    = err_q;
`else
  assign load_err    = 1'b0;
`endif

endmodule
